// File: rtl/modinv_loop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : modinv_loop_sequencer
// Description : Control sequencer for the modular-inversion core. It starts
//               the init helper, then runs the almost-inverse loop: test,
//               choose one of four update ops from the returned flags, and
//               update, until v reaches zero. It owns only control and the
//               iteration count k.
//               Optional feature macro: MODINV_SEQ_TIMEOUT_EN (iteration
//               limit of 2*OPERAND_WIDTH, reported on err).
// Revision    : 1.0 - initial release
// ============================================================================
module modinv_loop_sequencer #(
  parameter int OPERAND_WIDTH = 256,
  parameter int K_BITS        = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  output logic              rdy,
  output logic [K_BITS-1:0] k,
  output logic              err,
  output logic              init_ena,
  input  logic              init_rdy,
  output logic              test_ena,
  input  logic              test_rdy,
  input  logic              v_zero,
  input  logic              u_even,
  input  logic              v_even,
  input  logic              u_gt_v,
  output logic              upd_ena,
  output logic [1:0]        upd_op,
  input  logic              upd_rdy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT_GO   = 3'd1,
    S_INIT_WAIT = 3'd2,
    S_TEST_GO   = 3'd3,
    S_TEST_WAIT = 3'd4,
    S_DECIDE    = 3'd5,
    S_UPD_GO    = 3'd6,
    S_UPD_WAIT  = 3'd7
  } state_t;

  state_t            state_q;
  logic              skip_q;
  logic              rdy_q;
  logic              init_ena_q;
  logic              test_ena_q;
  logic              upd_ena_q;
  logic [1:0]        upd_op_q;
  logic [1:0]        upd_op_d;
  logic [K_BITS-1:0] k_q;

`ifdef MODINV_SEQ_TIMEOUT_EN
  localparam logic [K_BITS-1:0] C_K_LIMIT = K_BITS'(2 * OPERAND_WIDTH);
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign rdy      = rdy_q;
  assign k        = k_q;
  assign init_ena = init_ena_q;
  assign test_ena = test_ena_q;
  assign upd_ena  = upd_ena_q;
  assign upd_op   = upd_op_q;

  // Update opcode chosen from the test flags, highest priority first.
  always_comb begin
    upd_op_d = 2'd3;
    if (u_even)      upd_op_d = 2'd0;
    else if (v_even) upd_op_d = 2'd1;
    else if (u_gt_v) upd_op_d = 2'd2;
  end

  // Sequencer FSM with registered outputs. A helper only lowers its rdy the
  // cycle after it sees ena, so the first WAIT cycle ignores helper rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      skip_q     <= 1'b0;
      rdy_q      <= 1'b1;
      init_ena_q <= 1'b0;
      test_ena_q <= 1'b0;
      upd_ena_q  <= 1'b0;
      upd_op_q   <= 2'd0;
      k_q        <= '0;
`ifdef MODINV_SEQ_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      init_ena_q <= 1'b0;
      test_ena_q <= 1'b0;
      upd_ena_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ena) begin
            state_q    <= S_INIT_GO;
            rdy_q      <= 1'b0;
            init_ena_q <= 1'b1;
            k_q        <= '0;
`ifdef MODINV_SEQ_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
          end
        end
        S_INIT_GO: begin
          state_q <= S_INIT_WAIT;
          skip_q  <= 1'b1;
        end
        S_INIT_WAIT: begin
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (init_rdy) begin
            state_q    <= S_TEST_GO;
            test_ena_q <= 1'b1;
          end
        end
        S_TEST_GO: begin
          state_q <= S_TEST_WAIT;
          skip_q  <= 1'b1;
        end
        S_TEST_WAIT: begin
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (test_rdy) begin
            state_q <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          if (v_zero) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b1;
`ifdef MODINV_SEQ_TIMEOUT_EN
          end else if (k_q == C_K_LIMIT) begin
            // Loop failed to converge within the budget: abort without update.
            state_q <= S_IDLE;
            rdy_q   <= 1'b1;
            err_q   <= 1'b1;
`endif
          end else begin
            state_q   <= S_UPD_GO;
            upd_ena_q <= 1'b1;
            upd_op_q  <= upd_op_d;
          end
        end
        S_UPD_GO: begin
          state_q <= S_UPD_WAIT;
          skip_q  <= 1'b1;
          k_q     <= k_q + K_BITS'(1);
        end
        S_UPD_WAIT: begin
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (upd_rdy) begin
            state_q    <= S_TEST_GO;
            test_ena_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
